// File: rtl/qspi_interface.svh
// rtl/qspi_interface.svh - shared QSPI command encodings and geometry constants
`ifndef QSPI_INTERFACE_SVH
`define QSPI_INTERFACE_SVH
package qspi_pkg;
  typedef enum logic [7:0] {
    CmdReset   = 8'h99,
    CmdPowerUp = 8'hAB,
    CmdRead    = 8'hEB
  } cmd_t;

  localparam int QSPI_ADDR_BITS    = 24;
  localparam int QSPI_LINE_BITS    = 128;
  localparam int QSPI_ADDR_NIBBLES = 6;
  localparam int QSPI_LINE_NIBBLES = QSPI_LINE_BITS / 4;
endpackage
`endif

// File: rtl/qspi_cnt.sv
// rtl/qspi_cnt.sv - 8-bit clearable, saturating cycle counter with target compare
module qspi_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [7:0] target,
  output logic       done
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 8'd0;
    end else if (count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign done = (count == target);

endmodule

// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - compilation unit carrying the qspi_pkg package
`include "qspi_interface.svh"

// File: rtl/qspi_datapath.sv
// rtl/qspi_datapath.sv - QSPI command/address/data datapath for cache line fills
// Optional QSPI_BYTE_SWAP_EN: present line_data byte-reversed (first byte at [7:0]).
module qspi_datapath
  import qspi_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  cmd_t                      cmd_in,
  input  logic                      cmd_we,
  input  logic [1:0]                out_mux,
  input  logic                      addr_shift,
  input  logic                      data_shift,
  input  logic [7:0]                cnt_val,
  input  logic                      cnt_we,
  input  logic                      cs,
  output logic                      cmd_last_cycle,
  output logic                      cmd_done,
  output logic                      addr_done,
  output logic                      cnt_done,
  input  logic [QSPI_ADDR_BITS-1:0] addr_in,
  output logic [QSPI_LINE_BITS-1:0] line_data,
  output logic                      line_valid,
  output logic                      qspi_cs_n,
  output logic [3:0]                io_out,
  output logic [3:0]                io_oe,
  input  logic [3:0]                io_in
);

  localparam logic [2:0] NIB_LAST = 3'(QSPI_ADDR_NIBBLES - 1);
  localparam logic [2:0] NIB_END  = 3'(QSPI_ADDR_NIBBLES);
  localparam logic [5:0] DATA_END = 6'(QSPI_LINE_NIBBLES);

  logic [7:0]                cmd_reg;
  logic [3:0]                bit_cnt;
  logic [QSPI_ADDR_BITS-1:0] addr_reg;
  logic [2:0]                nib_idx;
  logic [QSPI_LINE_BITS-1:0] line_reg;
  logic [5:0]                data_cnt;
  logic                      armed;
  logic                      cmd_adv;
  logic                      addr_adv;
  logic                      data_take;

  // armed is only set by cmd_we, so a reset mid-transfer blocks all shifting until reloaded
  assign cmd_adv   = armed && (out_mux == 2'd1) && !cs && (bit_cnt != 4'd8);
  assign addr_adv  = armed && addr_shift && (nib_idx != NIB_END);
  assign data_take = armed && data_shift && (data_cnt != DATA_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_reg    <= 8'd0;
      bit_cnt    <= 4'd0;
      addr_reg   <= '0;
      nib_idx    <= 3'd0;
      line_reg   <= '0;
      data_cnt   <= 6'd0;
      line_valid <= 1'b0;
      armed      <= 1'b0;
    end else if (cmd_we) begin
      cmd_reg    <= cmd_in;
      addr_reg   <= addr_in;
      bit_cnt    <= 4'd0;
      nib_idx    <= 3'd0;
      data_cnt   <= 6'd0;
      line_valid <= 1'b0;
      armed      <= 1'b1;
    end else begin
      line_valid <= data_take && (data_cnt == DATA_END - 6'd1);
      if (cmd_adv) begin
        cmd_reg <= {cmd_reg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (addr_adv) begin
        addr_reg <= {addr_reg[QSPI_ADDR_BITS-5:0], 4'd0};
        nib_idx  <= nib_idx + 3'd1;
      end
      if (data_take) begin
        line_reg <= {line_reg[QSPI_LINE_BITS-5:0], io_in};
        data_cnt <= data_cnt + 6'd1;
      end
    end
  end

  assign cmd_last_cycle = (out_mux == 2'd1) && (bit_cnt == 4'd7);
  assign cmd_done       = (bit_cnt == 4'd8);
  assign addr_done      = addr_shift && (nib_idx == NIB_LAST);
  assign qspi_cs_n      = cs;

  always_comb begin
    io_oe  = 4'b0000;
    io_out = 4'b0000;
    if (armed) begin
      case (out_mux)
        2'd1: begin
          io_oe  = 4'b0001;
          io_out = {3'b000, cmd_reg[7]};
        end
        2'd2: begin
          io_oe  = 4'b1111;
          io_out = addr_reg[QSPI_ADDR_BITS-1 -: 4];
        end
        default: begin
          io_oe  = 4'b0000;
          io_out = 4'b0000;
        end
      endcase
    end
  end

`ifdef QSPI_BYTE_SWAP_EN
  always_comb begin
    line_data = '0;
    for (int b = 0; b < QSPI_LINE_BITS / 8; b++) begin
      line_data[8*b +: 8] = line_reg[QSPI_LINE_BITS-8-8*b +: 8];
    end
  end
`else
  assign line_data = line_reg;
`endif

  qspi_cnt u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_we || cmd_we),
    .target (cnt_val),
    .done   (cnt_done)
  );

endmodule

// File: tb/tb_qspi_datapath.sv
// tb/tb_qspi_datapath.sv - directed self-checking bench for qspi_datapath
module tb_qspi_datapath;
  import qspi_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  cmd_t         cmd_in = CmdRead;
  logic         cmd_we = 1'b0;
  logic [1:0]   out_mux = 2'd0;
  logic         addr_shift = 1'b0;
  logic         data_shift = 1'b0;
  logic [7:0]   cnt_val = 8'd0;
  logic         cnt_we = 1'b0;
  logic         cs = 1'b1;
  logic         cmd_last_cycle, cmd_done, addr_done, cnt_done;
  logic [23:0]  addr_in = 24'h12ABCD;
  logic [127:0] line_data;
  logic         line_valid, qspi_cs_n;
  logic [3:0]   io_out, io_oe;
  logic [3:0]   io_in = 4'h0;

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_line;
  logic [127:0] exp_small;
  logic [7:0]   cmd_bits;
  logic [3:0]   addr_nibs [6];
  int           pulses;

  qspi_datapath dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_we(cmd_we), .out_mux(out_mux),
    .addr_shift(addr_shift), .data_shift(data_shift), .cnt_val(cnt_val),
    .cnt_we(cnt_we), .cs(cs), .cmd_last_cycle(cmd_last_cycle), .cmd_done(cmd_done),
    .addr_done(addr_done), .cnt_done(cnt_done), .addr_in(addr_in),
    .line_data(line_data), .line_valid(line_valid), .qspi_cs_n(qspi_cs_n),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef QSPI_BYTE_SWAP_EN
    exp_line  = 128'hEFCDAB8967452301EFCDAB8967452301;
    exp_small = 128'hAAAA0000000000000000000000000000;
`else
    exp_line  = 128'h0123456789ABCDEF0123456789ABCDEF;
    exp_small = 128'h0000000000000000000000000000AAAA;
`endif
    cmd_bits  = 8'b1110_1011;
    addr_nibs = '{4'h1, 4'h2, 4'hA, 4'hB, 4'hC, 4'hD};

    // reset state
    tick(); tick();
    check("rst_line_data", line_data, 128'd0);
    check("rst_line_valid", 128'(line_valid), 128'd0);
    check("rst_cmd_done", 128'(cmd_done), 128'd0);
    check("rst_cmd_last", 128'(cmd_last_cycle), 128'd0);
    check("rst_addr_done", 128'(addr_done), 128'd0);
    check("rst_io_oe", 128'(io_oe), 128'd0);
    check("rst_io_out", 128'(io_out), 128'd0);
    check("rst_cnt_done", 128'(cnt_done), 128'd1);
    check("rst_cs_n", 128'(qspi_cs_n), 128'd1);
    rst = 1'b0;

    // command shift
    cmd_in = CmdRead; cmd_we = 1'b1;
    tick();
    cmd_we = 1'b0; out_mux = 2'd1; cs = 1'b0;
    #1;
    check("cs_n_follow", 128'(qspi_cs_n), 128'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("cmd_bit%0d", i), 128'(io_out), 128'({3'b000, cmd_bits[7-i]}));
      check($sformatf("cmd_oe%0d", i), 128'(io_oe), 128'd1);
      check($sformatf("cmd_last%0d", i), 128'(cmd_last_cycle), 128'(i == 7));
      check($sformatf("cmd_done%0d", i), 128'(cmd_done), 128'd0);
      tick();
    end
    check("cmd_done_9th", 128'(cmd_done), 128'd1);
    check("cmd_last_9th", 128'(cmd_last_cycle), 128'd0);

    // address shift
    out_mux = 2'd2; addr_shift = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("addr_nib%0d", i), 128'(io_out), 128'(addr_nibs[i]));
      check($sformatf("addr_oe%0d", i), 128'(io_oe), 128'hF);
      check($sformatf("addr_done%0d", i), 128'(addr_done), 128'(i == 5));
      tick();
    end
    addr_shift = 1'b0;
    #1;
    check("addr_done_after", 128'(addr_done), 128'd0);
    out_mux = 2'd3;
    #1;
    check("mux3_oe", 128'(io_oe), 128'd0);
    check("mux3_out", 128'(io_out), 128'd0);
    out_mux = 2'd0; cs = 1'b1;

    // delay count
    cnt_we = 1'b1; cnt_val = 8'd6;
    tick();
    cnt_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("cnt_low%0d", i), 128'(cnt_done), 128'd0);
      tick();
    end
    check("cnt_high_7th", 128'(cnt_done), 128'd1);
    cnt_we = 1'b1; cnt_val = 8'd0;
    tick();
    cnt_we = 1'b0;
    #1;
    check("cnt_zero_after_clr", 128'(cnt_done), 128'd1);

    // data fill
    cmd_we = 1'b1;
    tick();
    cmd_we = 1'b0; data_shift = 1'b1;
    for (int i = 0; i < 32; i++) begin
      io_in = 4'(i);
      tick();
      if (i < 31) check($sformatf("fill_nv%0d", i), 128'(line_valid), 128'd0);
    end
    data_shift = 1'b0;
    check("fill_valid", 128'(line_valid), 128'd1);
    check("fill_line", line_data, exp_line);
    tick();
    check("fill_valid_once", 128'(line_valid), 128'd0);
    data_shift = 1'b1; io_in = 4'h7;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (line_valid) pulses++;
    end
    data_shift = 1'b0;
    check("over_no_valid", 128'(pulses), 128'd0);
    check("over_line_stable", line_data, exp_line);

    // reset mid-fill
    cmd_we = 1'b1;
    tick();
    cmd_we = 1'b0; data_shift = 1'b1; io_in = 4'h5;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_line", line_data, 128'd0);
    check("midrst_valid", 128'(line_valid), 128'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (line_valid) pulses++;
    end
    data_shift = 1'b0;
    check("midrst_no_valid", 128'(pulses), 128'd0);
    check("midrst_no_advance", line_data, 128'd0);

    // collision: cmd_we wins over data_shift
    cmd_we = 1'b1;
    tick();
    cmd_we = 1'b0; data_shift = 1'b1; io_in = 4'hA;
    for (int i = 0; i < 4; i++) tick();
    check("coll_pre", line_data, exp_small);
    cmd_we = 1'b1; io_in = 4'h3; cnt_val = 8'd0;
    tick();
    cmd_we = 1'b0;
    check("coll_line_unchanged", line_data, exp_small);
    check("coll_cnt_cleared", 128'(cnt_done), 128'd1);
    check("coll_cmd_done", 128'(cmd_done), 128'd0);
    io_in = 4'hF;
    pulses = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (line_valid) pulses++;
    end
    check("coll_no_early_valid", 128'(pulses), 128'd0);
    tick();
    data_shift = 1'b0;
    check("coll_valid_after_32", 128'(line_valid), 128'd1);
    check("coll_line_full", line_data, {128{1'b1}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
